// File: rtl/sine_pwm_dac.sv
// sine_pwm_dac: turns a free-running WIDTH-bit sample stream into a single-bit
// PWM waveform, latching one sample per 2^WIDTH-clock period.
// Optional macro SINE_PWM_DAC_COMPL_EN adds a dead-time protected
// complementary output on pwm_n_out; without it pwm_n_out is tied low.
module sine_pwm_dac #(
  parameter int WIDTH    = 8,
  parameter int DEADTIME = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic             pwm_out,
  output logic             pwm_n_out,
  output logic             period_start,
  output logic [WIDTH-1:0] duty_q,
  output logic             running
);

  localparam logic [0:0]       S_IDLE  = 1'b0;
  localparam logic [0:0]       S_RUN   = 1'b1;
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [0:0]       state, state_n;
  logic [WIDTH-1:0] cnt, cnt_n, duty_n;
  logic             start_n, raw_n, run_n;

  // Next-state view: every registered output is derived from these so that
  // the outputs in cycle k already reflect cnt=k (no extra output latency).
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    duty_n  = duty_q;
    start_n = 1'b0;
    case (state)
      S_IDLE: begin
        if (en) begin
          state_n = S_RUN;
          cnt_n   = '0;
          duty_n  = din;
          start_n = 1'b1;
        end
      end
      default: begin
        if (cnt == CNT_MAX) begin
          // en only matters at the period boundary, so periods never truncate
          cnt_n = '0;
          if (en) begin
            duty_n  = din;
            start_n = 1'b1;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
    endcase
    run_n = (state_n == S_RUN);
    raw_n = run_n && (cnt_n < duty_n);
  end

  // Core state, period counter, latched sample and status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      duty_q       <= '0;
      period_start <= 1'b0;
      running      <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      duty_q       <= duty_n;
      period_start <= start_n;
      running      <= run_n;
    end
  end

`ifdef SINE_PWM_DAC_COMPL_EN
  localparam logic [3:0] DT = 4'(DEADTIME);

  logic [3:0] dt, dt_n;
  logic       raw_q;

  // Dead-time counter restarts on every raw edge and saturates at DT
  always_comb begin
    if (raw_n != raw_q) dt_n = '0;
    else if (dt < DT)   dt_n = dt + 1'b1;
    else                dt_n = dt;
  end

  // Complementary outputs, each held off for DT cycles after a raw edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      raw_q     <= 1'b0;
      dt        <= '0;
      pwm_out   <= 1'b0;
      pwm_n_out <= 1'b0;
    end else begin
      raw_q     <= raw_n;
      dt        <= dt_n;
      pwm_out   <= raw_n && (dt_n >= DT);
      pwm_n_out <= run_n && !raw_n && (dt_n >= DT);
    end
  end
`else
  // Plain PWM output; complementary pin unused
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_out   <= 1'b0;
      pwm_n_out <= 1'b0;
    end else begin
      pwm_out   <= raw_n;
      pwm_n_out <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_sine_pwm_dac.sv
// Bench for sine_pwm_dac: per-cycle expected outputs are pushed to a queue
// before each clock edge and popped/compared mid-cycle afterwards.
module tb_sine_pwm_dac;
  localparam int WIDTH = 8;
  localparam int DT    = 2;
  localparam int P     = 1 << WIDTH;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic [WIDTH-1:0] din;
  logic             pwm_out, pwm_n_out, period_start, running;
  logic [WIDTH-1:0] duty_q;

  typedef struct packed {
    logic             pwm;
    logic             pwm_n;
    logic             ps;
    logic             run;
    logic [WIDTH-1:0] duty;
  } obs_t;

  obs_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  sine_pwm_dac #(.WIDTH(WIDTH), .DEADTIME(DT)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din),
    .pwm_out(pwm_out), .pwm_n_out(pwm_n_out), .period_start(period_start),
    .duty_q(duty_q), .running(running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs in cycle k of a period modulating duty d
  function automatic obs_t exp_run(input int k, input int d);
    obs_t e;
    e.ps   = (k == 0);
    e.run  = 1'b1;
    e.duty = WIDTH'(d);
`ifdef SINE_PWM_DAC_COMPL_EN
    e.pwm   = (k >= DT) && (k < d);
    e.pwm_n = (d > 0) ? (k >= d + DT) : 1'b1;
`else
    e.pwm   = (k < d);
    e.pwm_n = 1'b0;
`endif
    return e;
  endfunction

  function automatic obs_t exp_idle(input int d);
    obs_t e;
    e      = '0;
    e.duty = WIDTH'(d);
    return e;
  endfunction

  // One clock: expectation queued before the edge, checked mid-cycle after it
  task automatic tick(input string nm, input obs_t e);
    obs_t x, a;
    sbq.push_back(e);
    @(posedge clk);
    @(negedge clk);
    x = sbq.pop_front();
    a = {pwm_out, pwm_n_out, period_start, running, duty_q};
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s t=%0t: got pwm=%b pwm_n=%b ps=%b run=%b duty=%0d, want pwm=%b pwm_n=%b ps=%b run=%b duty=%0d",
               nm, $time, a.pwm, a.pwm_n, a.ps, a.run, a.duty,
               x.pwm, x.pwm_n, x.ps, x.run, x.duty);
    end
  endtask

  // Full period with duty d; din/en for cycle 0 already set by the caller.
  // en drops from cycle drop_k on; din is noise except from chg_k onward.
  task automatic run_period(input string nm, input int d, input int drop_k,
                            input int chg_k, input int chg_v);
    for (int k = 0; k < P; k++) begin
      if (k > 0) begin
        din = (k >= chg_k) ? WIDTH'(chg_v) : WIDTH'($urandom_range(0, P - 1));
        en  = (k < drop_k);
      end
      tick(nm, exp_run(k, d));
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; din = 8'd64;
    for (int i = 0; i < 3; i++) tick("reset_hold", '0);
    rst_n = 1'b1;
  endtask

  task automatic test_duty64();
    din = 8'd64; en = 1'b1;
    run_period("duty64_p0", 64, P, P, 0);
    din = 8'd64; en = 1'b1;
    run_period("duty64_p1", 64, P, P, 0);
  endtask

  task automatic test_extremes();
    din = 8'd0; en = 1'b1;
    run_period("din_zero", 0, P, P, 0);
    din = 8'd255; en = 1'b1;
    run_period("din_max", 255, P, P, 0);
  endtask

  task automatic test_din_change();
    din = 8'd64; en = 1'b1;
    run_period("din_chg_old", 64, P, 100, 200);
    en = 1'b1;
    run_period("din_chg_new", 200, P, P, 0);
  endtask

  task automatic test_en_drop();
    din = 8'd128; en = 1'b1;
    run_period("en_drop", 128, 10, P, 0);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      din = WIDTH'($urandom_range(0, P - 1));
      tick("en_drop_idle", exp_idle(128));
    end
  endtask

  task automatic test_reset_mid();
    din = 8'd64; en = 1'b1;
    for (int k = 0; k < 30; k++) begin
      if (k > 0) din = WIDTH'($urandom_range(0, P - 1));
      tick("rst_mid_run", exp_run(k, 64));
    end
    rst_n = 1'b0;
    tick("rst_mid_zero", '0);
    tick("rst_mid_zero", '0);
    rst_n = 1'b1; din = 8'd100; en = 1'b1;
    tick("rst_mid_restart", exp_run(0, 100));
    din = 8'd7;
    tick("rst_mid_restart", exp_run(1, 100));
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; din = '0;
    test_reset();
    test_duty64();
    test_extremes();
    test_din_change();
    test_en_drop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
